// File: rtl/rr_grant_sequencer_pkg.sv
// Shared definitions for the round-robin grant sequencer: sizes, FSM states
// and the rotating priority pick used during arbitration.
package rr_grant_sequencer_pkg;

    localparam int unsigned N     = 8;
    localparam int unsigned IDXW  = 3;
    localparam int unsigned HOLDW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // First requester at or after ptr, searching cyclically; one-hot result, zero if none.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input logic [IDXW-1:0] ptr);
        logic [N-1:0]    pick;
        logic [IDXW-1:0] k;
        logic            found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            k = ptr + IDXW'(i);
            if (!found && req[k]) begin
                pick[k] = 1'b1;
                found   = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_grant_sequencer_onehot_enc.sv
// One-hot to binary index encoder. Anything that is not exactly one-hot
// (including all-zero) encodes to index 0.
module rr_onehot_enc
    import rr_grant_sequencer_pkg::*;
(
    input  logic [N-1:0]    onehot,
    output logic [IDXW-1:0] idx
);

    // Explicit table so illegal patterns fall through to 0.
    always_comb begin
        idx = '0;
        case (onehot)
            8'b0000_0001: idx = 3'd0;
            8'b0000_0010: idx = 3'd1;
            8'b0000_0100: idx = 3'd2;
            8'b0000_1000: idx = 3'd3;
            8'b0001_0000: idx = 3'd4;
            8'b0010_0000: idx = 3'd5;
            8'b0100_0000: idx = 3'd6;
            8'b1000_0000: idx = 3'd7;
            default:      idx = '0;
        endcase
    end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter/sequencer for 8 requesters sharing one resource.
// Issues a registered one-hot grant with its index; a grant ends on DONE,
// on the owner dropping its request, or when the hold limit is reached.
// Every release is followed by one dead cycle before arbitration resumes.
module rr_grant_sequencer
    import rr_grant_sequencer_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    REQ,
    input  logic            DONE,
    output logic [N-1:0]    GNT,
    output logic [IDXW-1:0] GNT_IDX,
    output logic            GNT_VALID,
    output logic            TMO
);

    localparam logic [HOLDW-1:0] HOLD_LIMIT = HOLDW'(MAX_HOLD);

    state_t            state;
    logic [IDXW-1:0]   ptr;
    logic [HOLDW-1:0]  hold;
    logic [N-1:0]      pick_onehot;
    logic [IDXW-1:0]   pick_idx;
    logic              release_now;
    logic              limit_hit;

    // Candidate grant for this cycle, rotated from the round-robin pointer.
    always_comb begin
        pick_onehot = rr_pick(REQ, ptr);
    end

    rr_onehot_enc u_enc (
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // Release conditions while granted; DONE and a dropped request take
    // precedence over the hold limit, so TMO only fires for a pure timeout.
    always_comb begin
        limit_hit   = (hold == HOLD_LIMIT);
        release_now = DONE || !REQ[GNT_IDX] || limit_hit;
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold      <= '0;
            GNT       <= '0;
            GNT_IDX   <= '0;
            GNT_VALID <= 1'b0;
            TMO       <= 1'b0;
        end else begin
            TMO <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|REQ) begin
                        GNT       <= pick_onehot;
                        GNT_IDX   <= pick_idx;
                        GNT_VALID <= 1'b1;
                        hold      <= HOLDW'(1);
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        TMO       <= !DONE && REQ[GNT_IDX];
                        ptr       <= GNT_IDX + IDXW'(1);
                        hold      <= '0;
                        GNT       <= '0;
                        GNT_IDX   <= '0;
                        GNT_VALID <= 1'b0;
                        state     <= ST_GAP;
                    end else begin
                        hold <= hold + HOLDW'(1);
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed self-checking bench for rr_grant_sequencer.
module tb_rr_grant_sequencer;

    logic       CLK;
    logic       RST;
    logic [7:0] REQ;
    logic       DONE;
    logic [7:0] GNT;
    logic [2:0] GNT_IDX;
    logic       GNT_VALID;
    logic       TMO;

    int total = 0;
    int bad   = 0;

    rr_grant_sequencer #(.MAX_HOLD(15)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .DONE      (DONE),
        .GNT       (GNT),
        .GNT_IDX   (GNT_IDX),
        .GNT_VALID (GNT_VALID),
        .TMO       (TMO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] i,
                           input logic v, input logic t);
        chk({tag, ".gnt"}, 32'(GNT), 32'(g));
        chk({tag, ".idx"}, 32'(GNT_IDX), 32'(i));
        chk({tag, ".vld"}, 32'(GNT_VALID), 32'(v));
        chk({tag, ".tmo"}, 32'(TMO), 32'(t));
    endtask

    task automatic do_reset();
        RST  = 1'b1;
        REQ  = 8'h00;
        DONE = 1'b0;
        step();
        step();
        chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        RST = 1'b0;
    endtask

    // Expects grant to idx now, holds it `extra` more cycles, releases with
    // DONE, checks the two dead cycles and leaves the next grant visible.
    task automatic grant_done(input string tag, input int unsigned idx, input int unsigned extra);
        logic [7:0] g;
        g = 8'h01 << idx;
        chk_out(tag, g, 3'(idx), 1'b1, 1'b0);
        for (int unsigned n = 0; n < extra; n++) begin
            step();
            chk_out({tag, ".hold"}, g, 3'(idx), 1'b1, 1'b0);
        end
        DONE = 1'b1;
        step();
        chk_out({tag, ".rel"}, 8'h00, 3'd0, 1'b0, 1'b0);
        DONE = 1'b0;
        step();
        chk_out({tag, ".gap"}, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        RST  = 1'b1;
        REQ  = 8'h00;
        DONE = 1'b0;
        #1;

        // 1: single requester, DONE during cycle 4, pointer moves to 1
        do_reset();
        REQ = 8'h01;
        step();
        REQ = 8'hFF;
        grant_done("t1", 0, 3);
        chk_out("t1.ptr1", 8'h02, 3'd1, 1'b1, 1'b0);

        // 2: requesters 0 and 7 alternate, pointer wraps 7 -> 0
        do_reset();
        REQ = 8'h81;
        step();
        grant_done("t2a", 0, 0);
        grant_done("t2b", 7, 0);
        grant_done("t2c", 0, 0);
        grant_done("t2d", 7, 0);
        chk_out("t2e", 8'h01, 3'd0, 1'b1, 1'b0);

        // 3: all requesting, strict rotation 0..7 then 0
        do_reset();
        REQ = 8'hFF;
        step();
        for (int unsigned i = 0; i < 9; i++) grant_done("t3", i % 8, 1);

        // 4: lone requester held, forced release after 15 cycles
        do_reset();
        REQ = 8'h10;
        step();
        for (int unsigned i = 0; i < 15; i++) begin
            chk_out("t4.hold", 8'h10, 3'd4, 1'b1, 1'b0);
            step();
        end
        chk_out("t4.tmo", 8'h00, 3'd0, 1'b0, 1'b1);
        step();
        chk_out("t4.gap", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_out("t4.regrant", 8'h10, 3'd4, 1'b1, 1'b0);

        // 5: asynchronous reset mid-grant clears outputs and pointer
        do_reset();
        REQ = 8'h04;
        step();
        grant_done("t5a", 2, 0);
        chk_out("t5.mid", 8'h04, 3'd2, 1'b1, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        chk_out("t5.async", 8'h00, 3'd0, 1'b0, 1'b0);
        REQ = 8'hFF;
        step();
        RST = 1'b0;
        step();
        chk_out("t5.from0", 8'h01, 3'd0, 1'b1, 1'b0);

        // 6: owner drops request -> release without TMO, pointer 4;
        //    then DONE coinciding with the hold limit keeps TMO low
        do_reset();
        REQ = 8'h08;
        step();
        chk_out("t6.grant", 8'h08, 3'd3, 1'b1, 1'b0);
        REQ = 8'hF7;
        step();
        chk_out("t6.drop", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        step();
        chk_out("t6.ptr4", 8'h10, 3'd4, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 14; i++) begin
            step();
            chk_out("t6.hold", 8'h10, 3'd4, 1'b1, 1'b0);
        end
        DONE = 1'b1;
        step();
        chk_out("t6.donemax", 8'h00, 3'd0, 1'b0, 1'b0);
        DONE = 1'b0;
        step();
        chk_out("t6.gap", 8'h00, 3'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
